// File: rtl/sprite_layer_mapper_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_layer_mapper_if: object-table write bus for sprite_layer_mapper|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sprite_layer_mapper_if #(
   parameter int IDX_W = 4,
   parameter int GLY_W = 6
);
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [10:0]      wr_x;
   logic [10:0]      wr_y;
   logic [GLY_W-1:0] wr_glyph;
   logic [23:0]      wr_rgb;
   logic             wr_vis;

   modport master (
      output wr_en, wr_idx, wr_x, wr_y, wr_glyph, wr_rgb, wr_vis
   );

   modport slave (
      input  wr_en, wr_idx, wr_x, wr_y, wr_glyph, wr_rgb, wr_vis
   );
endinterface
`default_nettype wire

// File: rtl/sprite_layer_mapper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_layer_mapper: double-buffered sprite overlay, 3-cycle pipeline |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sprite_layer_mapper #(
   parameter int NUM_OBJ = 16,
   parameter int SPR_W   = 24,
   parameter int SPR_H   = 22,
   parameter int ROM_AW  = 11,
   parameter int IDX_W   = 4,
   parameter int GLY_W   = 6
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 pix_valid,
   input  logic [10:0]          DrawX,
   input  logic [10:0]          DrawY,
   input  logic [7:0]           bg_red,
   input  logic [7:0]           bg_green,
   input  logic [7:0]           bg_blue,
   input  logic                 frame_start,
   sprite_layer_mapper_if.slave wr,
   output logic [ROM_AW-1:0]    rom_addr,
   input  logic [SPR_W-1:0]     rom_data,
   output logic                 out_valid,
   output logic [7:0]           Red,
   output logic [7:0]           Green,
   output logic [7:0]           Blue,
   output logic [IDX_W-1:0]     hit_idx,
   output logic                 hit_any
);
   localparam int OFF_W = $clog2(SPR_W);

   typedef struct packed {
      logic [10:0]      x;
      logic [10:0]      y;
      logic [GLY_W-1:0] glyph;
      logic [23:0]      rgb;
      logic             vis;
   } obj_t;

   obj_t r_shadow [NUM_OBJ];
   obj_t r_active [NUM_OBJ];

   logic        r1_valid;
   logic [10:0] r1_x;
   logic [10:0] r1_y;
   logic [23:0] r1_bg;

   logic             w_hit;
   logic [IDX_W-1:0] w_idx;
   logic [OFF_W-1:0] w_off;
   logic [10:0]      w_dy;

   logic             r2_valid;
   logic             r2_hit;
   logic [IDX_W-1:0] r2_idx;
   logic [OFF_W-1:0] r2_off;
   logic [23:0]      r2_rgb;
   logic [23:0]      r2_bg;

   // 12-bit compares keep objects near column/row 2047 from wrapping to 0
   function automatic logic covers(input obj_t o, input logic [10:0] px, input logic [10:0] py);
      logic [11:0] x0;
      logic [11:0] y0;
      x0 = {1'b0, o.x};
      y0 = {1'b0, o.y};
      return o.vis
         && ({1'b0, px} >= x0) && ({1'b0, px} < x0 + 12'(SPR_W))
         && ({1'b0, py} >= y0) && ({1'b0, py} < y0 + 12'(SPR_H));
   endfunction

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         if (frame_start) begin
            r_active <= r_shadow;
         end
         if (wr.wr_en) begin
            r_shadow[wr.wr_idx] <= {wr.wr_x, wr.wr_y, wr.wr_glyph, wr.wr_rgb, wr.wr_vis};
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r1_valid <= 1'b0;
         r1_x     <= '0;
         r1_y     <= '0;
         r1_bg    <= '0;
      end else begin
         r1_valid <= pix_valid;
         r1_x     <= DrawX;
         r1_y     <= DrawY;
         r1_bg    <= {bg_red, bg_green, bg_blue};
      end
   end

   // Descending scan so the lowest-index covering object is left as winner
   always_comb begin
      w_hit = 1'b0;
      w_idx = '0;
      for (int i = NUM_OBJ - 1; i >= 0; i--) begin
         if (r1_valid && covers(r_active[i], r1_x, r1_y)) begin
            w_hit = 1'b1;
            w_idx = IDX_W'(i);
         end
      end
      w_off = OFF_W'(r1_x - r_active[w_idx].x);
      w_dy  = r1_y - r_active[w_idx].y;
   end

   assign rom_addr = w_hit ? ROM_AW'(32'(r_active[w_idx].glyph) * SPR_H + 32'(w_dy)) : '0;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r2_valid <= 1'b0;
         r2_hit   <= 1'b0;
         r2_idx   <= '0;
         r2_off   <= '0;
         r2_rgb   <= '0;
         r2_bg    <= '0;
      end else begin
         r2_valid <= r1_valid;
         r2_hit   <= w_hit;
         r2_idx   <= w_idx;
         r2_off   <= w_off;
         r2_rgb   <= r_active[w_idx].rgb;
         r2_bg    <= r1_bg;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n || !r2_valid) begin
         out_valid           <= 1'b0;
         {Red, Green, Blue}  <= '0;
         hit_any             <= 1'b0;
         hit_idx             <= '0;
      end else if (r2_hit && rom_data[r2_off]) begin
         out_valid           <= 1'b1;
         {Red, Green, Blue}  <= r2_rgb;
         hit_any             <= 1'b1;
         hit_idx             <= r2_idx;
      end else begin
         // A transparent winner pixel shows background, never a lower object
         out_valid           <= 1'b1;
         {Red, Green, Blue}  <= r2_bg;
         hit_any             <= 1'b0;
         hit_idx             <= '0;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_sprite_layer_mapper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sprite_layer_mapper: directed vector bench for sprite_layer_mapper |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sprite_layer_mapper;
   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        pix_valid = 1'b0;
   logic [10:0] DrawX = '0;
   logic [10:0] DrawY = '0;
   logic [7:0]  bg_red = '0;
   logic [7:0]  bg_green = '0;
   logic [7:0]  bg_blue = '0;
   logic        frame_start = 1'b0;
   logic [10:0] rom_addr;
   logic [23:0] rom_data = '0;
   logic        out_valid;
   logic [7:0]  Red;
   logic [7:0]  Green;
   logic [7:0]  Blue;
   logic [3:0]  hit_idx;
   logic        hit_any;

   logic [23:0] rom_mem [0:2047];

   int vectors = 0;
   int miscompares = 0;

   always #5 Clk = ~Clk;

   sprite_layer_mapper_if #(.IDX_W(4), .GLY_W(6)) wr_bus ();

   sprite_layer_mapper dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .pix_valid   (pix_valid),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .bg_red      (bg_red),
      .bg_green    (bg_green),
      .bg_blue     (bg_blue),
      .frame_start (frame_start),
      .wr          (wr_bus),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .out_valid   (out_valid),
      .Red         (Red),
      .Green       (Green),
      .Blue        (Blue),
      .hit_idx     (hit_idx),
      .hit_any     (hit_any)
   );

   // Synchronous glyph ROM: row returned one cycle after its address
   always @(posedge Clk) rom_data <= rom_mem[rom_addr];

   typedef struct {
      string       name;
      logic [10:0] x;
      logic [10:0] y;
      logic [23:0] bg;
      logic [23:0] rgb;
      logic        hit;
      logic [3:0]  idx;
      logic [10:0] addr;
   } vec_t;

   vec_t tab [15];

   task automatic write_obj(input logic [3:0] idx, input logic [10:0] x, input logic [10:0] y,
                            input logic [5:0] g, input logic [23:0] rgb, input logic vis,
                            input logic fs);
      @(negedge Clk);
      wr_bus.wr_en = 1'b1; wr_bus.wr_idx = idx; wr_bus.wr_x = x; wr_bus.wr_y = y;
      wr_bus.wr_glyph = g; wr_bus.wr_rgb = rgb; wr_bus.wr_vis = vis;
      frame_start = fs;
      @(negedge Clk);
      wr_bus.wr_en = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic pulse_fs();
      @(negedge Clk);
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
   endtask

   task automatic check_pixel(input string name, input logic [10:0] x, input logic [10:0] y,
                              input logic [23:0] bg, input logic [23:0] exp_rgb,
                              input logic exp_hit, input logic [3:0] exp_idx,
                              input logic [10:0] exp_addr);
      logic [10:0] a;
      logic        early;
      logic        v;
      logic [23:0] rgb;
      logic        h;
      logic [3:0]  id;
      @(negedge Clk);
      pix_valid = 1'b1; DrawX = x; DrawY = y;
      {bg_red, bg_green, bg_blue} = bg;
      @(negedge Clk);
      pix_valid = 1'b0;
      a = rom_addr;
      @(negedge Clk);
      early = out_valid;
      @(negedge Clk);
      v = out_valid; rgb = {Red, Green, Blue}; h = hit_any; id = hit_idx;
      vectors++;
      if (a !== exp_addr || early !== 1'b0 || v !== 1'b1 || rgb !== exp_rgb
          || h !== exp_hit || id !== exp_idx) begin
         miscompares++;
         $display("FAIL %s: got addr=%0d early_valid=%b valid=%b rgb=%06h hit=%b idx=%0d, need addr=%0d early_valid=0 valid=1 rgb=%06h hit=%b idx=%0d",
                  name, a, early, v, rgb, h, id, exp_addr, exp_rgb, exp_hit, exp_idx);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wr_bus.wr_en = 1'b0; wr_bus.wr_idx = '0; wr_bus.wr_x = '0; wr_bus.wr_y = '0;
      wr_bus.wr_glyph = '0; wr_bus.wr_rgb = '0; wr_bus.wr_vis = 1'b0;
      for (int i = 0; i < 2048; i++) rom_mem[i] = '0;
      rom_mem[0]   = 24'hFFFFFF;
      rom_mem[115] = 24'h000001;
      rom_mem[22]  = 24'hFFFFFF;
      rom_mem[23]  = 24'h000000;
      rom_mem[44]  = 24'h000001;
      rom_mem[49]  = 24'hFFFFFF;
      rom_mem[50]  = 24'hFFFFFF;
      rom_mem[66]  = 24'h000080;
      rom_mem[88]  = 24'h800000;
      rom_mem[109] = 24'h000001;

      tab[0]  = '{"basic_opaque",      400, 445, 24'h00AA00, 24'h000000, 1'b1, 4'd0, 11'd115};
      tab[1]  = '{"basic_transparent", 401, 445, 24'h00AA00, 24'h00AA00, 1'b0, 4'd0, 11'd115};
      tab[2]  = '{"prio_obj2_wins",    100, 100, 24'h112233, 24'hFF0000, 1'b1, 4'd2, 11'd22};
      tab[3]  = '{"prio_no_fallthru",  100, 101, 24'h112233, 24'h112233, 1'b0, 4'd0, 11'd23};
      tab[4]  = '{"obj7_alone",         90,  95, 24'h445566, 24'h0000FF, 1'b1, 4'd7, 11'd44};
      tab[5]  = '{"edge_x2047",       2047,   0, 24'h010203, 24'h123456, 1'b1, 4'd3, 11'd66};
      tab[6]  = '{"edge_x2040_transp",2040,   0, 24'h010203, 24'h010203, 1'b0, 4'd0, 11'd66};
      tab[7]  = '{"nowrap_x0",           0,   0, 24'h0A0B0C, 24'h0A0B0C, 1'b0, 4'd0, 11'd0};
      tab[8]  = '{"nowrap_x15",         15,   0, 24'h0A0B0C, 24'h0A0B0C, 1'b0, 4'd0, 11'd0};
      tab[9]  = '{"right_col_x23",     623, 300, 24'h777777, 24'hABCDEF, 1'b1, 4'd4, 11'd88};
      tab[10] = '{"right_out_x24",     624, 300, 24'h777777, 24'h777777, 1'b0, 4'd0, 11'd0};
      tab[11] = '{"left_out",          599, 300, 24'h777777, 24'h777777, 1'b0, 4'd0, 11'd0};
      tab[12] = '{"bottom_row21",      600, 321, 24'h777777, 24'hABCDEF, 1'b1, 4'd4, 11'd109};
      tab[13] = '{"bottom_out_row22",  600, 322, 24'h777777, 24'h777777, 1'b0, 4'd0, 11'd0};
      tab[14] = '{"top_out",           600, 299, 24'h777777, 24'h777777, 1'b0, 4'd0, 11'd0};

      // Reset state
      pix_valid = 1'b1;
      repeat (3) @(negedge Clk);
      vectors++;
      if (out_valid !== 1'b0 || {Red, Green, Blue} !== 24'h0 || hit_any !== 1'b0
          || hit_idx !== 4'd0 || rom_addr !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_state: got valid=%b rgb=%06h hit=%b idx=%0d addr=%0d, need all zero",
                  out_valid, {Red, Green, Blue}, hit_any, hit_idx, rom_addr);
      end
      pix_valid = 1'b0;
      Reset_n = 1'b1;
      repeat (4) @(negedge Clk);

      write_obj(4'd0, 11'd400, 11'd440, 6'd5, 24'h000000, 1'b1, 1'b0);
      write_obj(4'd2, 11'd100, 11'd100, 6'd1, 24'hFF0000, 1'b1, 1'b0);
      write_obj(4'd7, 11'd90,  11'd95,  6'd2, 24'h0000FF, 1'b1, 1'b0);
      write_obj(4'd3, 11'd2040, 11'd0,  6'd3, 24'h123456, 1'b1, 1'b0);
      write_obj(4'd4, 11'd600, 11'd300, 6'd4, 24'hABCDEF, 1'b1, 1'b0);
      pulse_fs();

      for (int i = 0; i < 15; i++)
         check_pixel(tab[i].name, tab[i].x, tab[i].y, tab[i].bg,
                     tab[i].rgb, tab[i].hit, tab[i].idx, tab[i].addr);

      // Hidden higher-priority object hands the pixel to the next one
      write_obj(4'd2, 11'd100, 11'd100, 6'd1, 24'hFF0000, 1'b0, 1'b0);
      pulse_fs();
      check_pixel("prio_obj2_hidden", 100, 100, 24'h112233, 24'h0000FF, 1'b1, 4'd7, 11'd49);

      // Double buffering
      write_obj(4'd1, 11'd10, 11'd10, 6'd0, 24'h00FF00, 1'b1, 1'b0);
      check_pixel("dbuf_before_swap", 10, 10, 24'h333333, 24'h333333, 1'b0, 4'd0, 11'd0);
      pulse_fs();
      check_pixel("dbuf_after_swap", 10, 10, 24'h333333, 24'h00FF00, 1'b1, 4'd1, 11'd0);
      write_obj(4'd1, 11'd10, 11'd10, 6'd0, 24'hFF00FF, 1'b1, 1'b1);
      check_pixel("dbuf_coincident", 10, 10, 24'h333333, 24'h00FF00, 1'b1, 4'd1, 11'd0);
      pulse_fs();
      check_pixel("dbuf_second_swap", 10, 10, 24'h333333, 24'hFF00FF, 1'b1, 4'd1, 11'd0);

      // 640-pixel stream: output k appears 3 cycles after input k, back to back
      for (int c = 0; c < 646; c++) begin
         logic        ev;
         logic [23:0] eb;
         @(negedge Clk);
         ev = (c >= 3 && c < 643);
         eb = {8'(c - 3), 8'((c - 3) >> 8), 8'h5A};
         vectors++;
         if (out_valid !== ev || (ev && ({Red, Green, Blue} !== eb || hit_any !== 1'b0))) begin
            miscompares++;
            $display("FAIL stream[%0d]: got valid=%b rgb=%06h hit=%b, need valid=%b rgb=%06h hit=0",
                     c, out_valid, {Red, Green, Blue}, hit_any, ev, eb);
         end
         pix_valid = (c < 640);
         DrawX = 11'(c);
         DrawY = 11'd0;
         {bg_red, bg_green, bg_blue} = {8'(c), 8'(c >> 8), 8'h5A};
      end
      pix_valid = 1'b0;

      // Mid-stream reset with a write and a swap on the same edge
      for (int c = 0; c < 12; c++) begin
         logic        ev;
         logic [23:0] eb;
         @(negedge Clk);
         ev = (c == 3 || c == 4 || c >= 8);
         eb = {8'(c - 2), 8'hC3, 8'h3C};
         vectors++;
         if (out_valid !== ev || (ev && {Red, Green, Blue} !== eb)
             || (!ev && ({Red, Green, Blue} !== 24'h0 || hit_any !== 1'b0 || hit_idx !== 4'd0))
             || (c == 5 && rom_addr !== 11'd0)) begin
            miscompares++;
            $display("FAIL reset_stream[%0d]: got valid=%b rgb=%06h hit=%b idx=%0d addr=%0d, need valid=%b rgb=%06h",
                     c, out_valid, {Red, Green, Blue}, hit_any, hit_idx, rom_addr, ev,
                     ev ? eb : 24'h0);
         end
         pix_valid = (c <= 8);
         DrawX = 11'(c + 100);
         DrawY = 11'd0;
         {bg_red, bg_green, bg_blue} = {8'(c + 1), 8'hC3, 8'h3C};
         Reset_n = (c != 4);
         frame_start = (c == 4);
         wr_bus.wr_en = (c == 4);
         wr_bus.wr_idx = 4'd0; wr_bus.wr_x = 11'd400; wr_bus.wr_y = 11'd440;
         wr_bus.wr_glyph = 6'd5; wr_bus.wr_rgb = 24'h000000; wr_bus.wr_vis = 1'b1;
      end
      pix_valid = 1'b0;
      Reset_n = 1'b1;
      frame_start = 1'b0;
      wr_bus.wr_en = 1'b0;
      repeat (4) @(negedge Clk);

      check_pixel("reset_active_cleared", 400, 445, 24'h00AA00, 24'h00AA00, 1'b0, 4'd0, 11'd0);
      pulse_fs();
      check_pixel("reset_shadow_cleared", 400, 445, 24'h00AA00, 24'h00AA00, 1'b0, 4'd0, 11'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/sprite_layer_mapper.md
SPRITE_LAYER_MAPPER -- requirements
Module: sprite_layer_mapper

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_OBJ, 16: number of sprite objects.
- SPR_W, 24: sprite width in pixels.
- SPR_H, 22: sprite height in rows.
- ROM_AW, 11: glyph ROM address width.
- IDX_W, 4: object index width; equals clog2(NUM_OBJ).
- GLY_W, 6: glyph number width.

REQ-002 Ports (name, direction, width, meaning):
- Clk, in, 1: sole clock; all state updates on its rising edge.
- Reset_n, in, 1: synchronous, active-low reset.
- pix_valid, in, 1: DrawX/DrawY/bg_* valid this cycle.
- DrawX, in, 11: pixel column.
- DrawY, in, 11: pixel row.
- bg_red, bg_green, bg_blue, in, 8 each: background colour for this pixel.
- frame_start, in, 1: one-cycle pulse at start of vertical blank.
- wr_en, in, 1: object-table write strobe.
- wr_idx, in, IDX_W: object being written.
- wr_x, in, 11: object left edge.
- wr_y, in, 11: object top edge.
- wr_glyph, in, GLY_W: glyph number.
- wr_rgb, in, 24: foreground colour, {R,G,B}.
- wr_vis, in, 1: object enable.
- rom_addr, out, ROM_AW: glyph ROM row address.
- rom_data, in, SPR_W: ROM row; bit [0] is the leftmost pixel; returned one cycle after rom_addr.
- out_valid, out, 1: Red/Green/Blue valid.
- Red, Green, Blue, out, 8 each: final pixel colour.
- hit_idx, out, IDX_W: winning object for this pixel; 0 when no object covers it.
- hit_any, out, 1: an opaque sprite pixel won.

Function
REQ-003 Two object tables SHALL be kept, each holding NUM_OBJ entries of {x, y, glyph, rgb, vis}: shadow and active.
REQ-004 A write with wr_en=1 SHALL update shadow[wr_idx] on the same edge; the active table SHALL NOT change on a write.
REQ-005 On frame_start=1, active SHALL be loaded with shadow's pre-edge contents; a write on the same cycle SHALL go to shadow only and SHALL take effect at the next frame_start.
REQ-006 Pipeline, one pixel per cycle, no stalls:
- S1: register inputs.
- S2: hit detection and rom_addr.
- S3: ROM return.
- S4: output registers.
- Latency pix_valid->out_valid SHALL be exactly 3 cycles.
REQ-007 Object i SHALL hit when all hold: vis=1; x <= DrawX < x+SPR_W; y <= DrawY < y+SPR_H. Comparisons SHALL use 12-bit zero-extended arithmetic, so an object near 2047 SHALL NOT wrap to column/row 0.
REQ-008 When several objects hit, the lowest index SHALL win; only the winner SHALL be looked up.
REQ-009 rom_addr SHALL be glyph*SPR_H + (DrawY - y), truncated to ROM_AW bits; with no hit, rom_addr SHALL be 0.
REQ-010 The column offset (DrawX - x), the winner's rgb, the hit flag and bg_* SHALL be delayed to align with rom_data.
REQ-011 If hit and rom_data[offset]=1, the output SHALL be the winner's rgb, with hit_any=1 and hit_idx=winner. Otherwise the output SHALL be the delayed bg_*, with hit_any=0 and hit_idx=0. A transparent winner pixel SHALL NOT fall through to lower-priority objects.
REQ-012 When the delayed pix_valid=0: out_valid=0, Red/Green/Blue=0, hit_any=0, hit_idx=0.
REQ-013 An active-table swap SHALL affect only pixels entering S2 after the swap edge; pixels already in flight SHALL finish with the old table.

Reset
REQ-014 Reset_n=0 at an edge SHALL:
- clear both tables (all vis=0, all fields 0);
- clear all pipeline valid bits;
- drive rom_addr=0, out_valid=0, Red=Green=Blue=0, hit_any=0, hit_idx=0.
REQ-015 Reset SHALL take priority over wr_en and frame_start on the same edge. Reset mid-frame SHALL discard in-flight pixels: no out_valid for 3 cycles after release, even with pix_valid=1.

Verification
REQ-016 Basic hit:
- Setup: write obj0 {x=400, y=440, glyph=5, rgb=000000, vis=1}; pulse frame_start; drive DrawX=400, DrawY=445, bg=00AA00.
- Response: rom_addr=115 one cycle after S1. Three cycles after input, the output is 000000 if rom_data[0]=1, else 00AA00.
REQ-017 Priority:
- Setup: obj2 and obj7 overlap at (100,100) with opaque bits.
- Response: hit_idx=2 and obj2's rgb. With obj2 vis=0, hit_idx=7.
REQ-018 Double buffer:
- Setup: write obj0 x=10 without frame_start.
- Response: pixel (10,y0) shows background. After frame_start it shows the sprite. A write coincident with frame_start appears only after the second frame_start.
REQ-019 Edge and no wrap:
- Setup: obj at x=2040, y=0.
- Response: DrawX=2047 hits with offset 7; DrawX=0..15 does not hit. DrawX=x+23 hits; x+24 does not.
REQ-020 Throughput and reset:
- Setup: stream 640 consecutive valid pixels.
- Response: 640 consecutive out_valid cycles, starting exactly 3 cycles later.
- Setup: assert Reset_n=0 mid-stream for 1 cycle.
- Response: outputs 0 the next cycle, and all tables show vis=0.
